clk_ratio_meter: RTL and testbench
==================================

# clk_ratio_meter

Measures the period and high time of a slow periodic signal that is synchronous to `clk`, and declares lock once the waveform is stable at 50 % duty. It is the receive-side checker for the clock-divider outputs (div2/div4/div8 and similar). It sits next to the divider and reports the measured ratio. It also flags a lost or distorted divided clock so that control logic can react.

## Interface
- `CNT_W`, 8: width of the period and high-time counters and outputs.
- `LOCK_CNT`, 4: number of consecutive matching measurements after the reference measurement that are required for lock; must be ≥1.
- `TIMEOUT`, 255: number of cycles without a rising edge after which the signal is declared lost; must be ≤ 2^CNT_W−1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `sig_in`  in  1  measured signal, synchronous to `clk`; no synchroniser inside.
- `period`  out  CNT_W  last measured period, in `clk` cycles.
- `high_time`  out  CNT_W  last measured number of high samples within one period.
- `meas_valid`  out  1  one-cycle pulse when `period` and `high_time` update.
- `duty_ok`  out  1  `2*high_time == period` for the last measurement.
- `locked`  out  1  stable measurement established.
- `err`  out  1  one-cycle pulse on loss of lock or on timeout.

## Operation
- Reset values: all outputs 0; internal counters 0; `prev` (the registered `sig_in`) = 1, so a signal that is high at reset release does not produce a false edge; state IDLE.
- Rise: `rise = sig_in & ~prev` each cycle. `prev <= sig_in` every cycle.
- Counters:
  - `cnt`: on `rise`, `cnt <= 1`; otherwise `cnt <= cnt+1`, saturating at 2^CNT_W−1.
  - `hcnt`: on `rise`, `hcnt <= 1`; otherwise it increments when `sig_in` = 1, saturating.
- States:
  - IDLE: counters run; the first `rise` moves to MEASURE. No `meas_valid` is produced in this state, because the partial period is discarded.
  - MEASURE: on each `rise`:
    - `period <= cnt`, `high_time <= hcnt`, `meas_valid` pulses, `duty_ok` updates.
    - A measurement matches if `period == ref` and duty is OK.
    - On a match, `match_cnt++`. When `match_cnt` reaches LOCK_CNT, move to LOCKED and set `locked` = 1.
    - On a mismatch (including the first measurement, when `ref` is invalid), load `ref` with the new period and set `match_cnt = 0`.
  - LOCKED: every `rise` still updates the outputs and pulses `meas_valid`.
    - A matching measurement keeps the lock.
    - A mismatch clears `locked`, pulses `err`, reloads `ref` with the new period, sets `match_cnt = 0`, and moves to MEASURE.
- Timeout: in MEASURE or LOCKED, if `cnt` reaches TIMEOUT with no `rise` on that cycle:
  - move to IDLE;
  - `locked` = 0;
  - `err` pulses (once, on entry);
  - `ref` becomes invalid and `match_cnt` = 0.
- Simultaneous events: a `rise` on the same cycle that `cnt` reaches TIMEOUT is a measurement, not a timeout.
- Odd periods always give `duty_ok` = 0 and therefore never lock.
- Reset asserted at any point returns every output and the state machine to reset values on the next edge.

## Timing
- All outputs are registered.
- For a `rise` sampled at edge k, `period`, `high_time`, `duty_ok`, `locked` and `err` update at k and are visible from k+1. `meas_valid` is high for exactly the cycle after k.
- Latency to lock: LOCK_CNT+2 rising edges from the first one (one discarded, one reference, LOCK_CNT matches).
- Minimum measurable period is 2 cycles. A constant input produces no edges and times out.

## Structure
- Shared package `clk_meas_pkg`: state enum (IDLE, MEASURE, LOCKED) and the default constants for CNT_W, LOCK_CNT and TIMEOUT.
- One natural sub-module, `rise_det`: owns `prev` with reset value 1 and outputs `rise`.
- The counters, comparison and FSM live in the top module.

## Test plan
- div2 pattern (toggle every cycle), LOCK_CNT=4:
  - every `meas_valid` reports `period` = 2, `high_time` = 1, `duty_ok` = 1;
  - `locked` rises after the 6th rising edge; `err` never pulses.
- div8 pattern (4 high, 4 low): `period` = 8, `high_time` = 4; `locked` = 1 after 6 rises, 40 cycles after the first rise.
- Locked on div4, then switch to div8:
  - the first 8-period measurement pulses `err` and clears `locked`;
  - relock occurs 4 matching measurements later with `period` = 8.
- Locked on div4, then hold `sig_in` at 0:
  - `err` pulses exactly once, TIMEOUT cycles after the last rise;
  - state returns to IDLE and no `meas_valid` is produced.
- Pattern with period 5 (3 high, 2 low): `duty_ok` = 0 on every measurement and `locked` stays 0.
- `sig_in` high at reset release, then a div4 pattern: no measurement before the first real 0→1 transition. Asserting `reset` mid-lock clears all outputs on the next edge.

Source files
------------

// File: rtl/clk_meas_pkg.sv
// Shared types and default constants for the divided-clock ratio meter.
package clk_meas_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int DEF_CNT_W    = 8;
    localparam int DEF_LOCK_CNT = 4;
    localparam int DEF_TIMEOUT  = 255;

endpackage

// File: rtl/clk_ratio_meter_rise_det.sv
// Rising-edge detector for a clk-synchronous input; prev resets high so a
// signal already high at reset release is not mistaken for an edge.
module rise_det (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = sig_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = sig_in & ~prev_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a slow clk-synchronous waveform and
// declares lock once the same 50 % duty period repeats LOCK_CNT times.
module clk_ratio_meter
    import clk_meas_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             duty_ok,
    output logic             locked,
    output logic             err
);

    localparam int               MC_W    = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [MC_W-1:0]  MC_LOCK = MC_W'(LOCK_CNT);

    logic rise;

    rise_det u_rise_det (
        .clk    (clk),
        .reset  (reset),
        .sig_in (sig_in),
        .rise   (rise)
    );

    state_t           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [CNT_W-1:0] hcnt_q,       hcnt_d;
    logic [CNT_W-1:0] ref_period_q, ref_period_d;
    logic             ref_valid_q,  ref_valid_d;
    logic [MC_W-1:0]  match_cnt_q,  match_cnt_d;
    logic [CNT_W-1:0] period_q,     period_d;
    logic [CNT_W-1:0] high_time_q,  high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             duty_ok_q,    duty_ok_d;
    logic             locked_q,     locked_d;
    logic             err_q,        err_d;

    logic             duty_now;
    logic             match_now;
    logic [MC_W-1:0]  mc_inc;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hcnt_d       = hcnt_q;
        ref_period_d = ref_period_q;
        ref_valid_d  = ref_valid_q;
        match_cnt_d  = match_cnt_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        duty_ok_d    = duty_ok_q;
        locked_d     = locked_q;
        err_d        = 1'b0;

        // Compare in CNT_W+1 bits so 2*hcnt cannot wrap.
        duty_now  = ({hcnt_q, 1'b0} == {1'b0, cnt_q});
        match_now = ref_valid_q && (cnt_q == ref_period_q) && duty_now;
        mc_inc    = match_cnt_q + MC_W'(1);

        if (rise) begin
            cnt_d  = CNT_W'(1);
            hcnt_d = CNT_W'(1);
        end else begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            if (sig_in && (hcnt_q != CNT_MAX)) begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                // The period in progress at start-up is partial; skip it.
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE, LOCKED: begin
                if (rise) begin
                    period_d     = cnt_q;
                    high_time_d  = hcnt_q;
                    meas_valid_d = 1'b1;
                    duty_ok_d    = duty_now;
                    if (match_now) begin
                        if (state_q == MEASURE) begin
                            match_cnt_d = mc_inc;
                            if (mc_inc == MC_LOCK) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end
                    end else begin
                        ref_period_d = cnt_q;
                        ref_valid_d  = 1'b1;
                        match_cnt_d  = '0;
                        if (state_q == LOCKED) begin
                            state_d  = MEASURE;
                            locked_d = 1'b0;
                            err_d    = 1'b1;
                        end
                    end
                end else if (cnt_q >= TO_VAL) begin
                    state_d     = IDLE;
                    locked_d    = 1'b0;
                    err_d       = 1'b1;
                    ref_valid_d = 1'b0;
                    match_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            ref_period_q <= '0;
            ref_valid_q  <= 1'b0;
            match_cnt_q  <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            duty_ok_q    <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hcnt_q       <= hcnt_d;
            ref_period_q <= ref_period_d;
            ref_valid_q  <= ref_valid_d;
            match_cnt_q  <= match_cnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            duty_ok_q    <= duty_ok_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign duty_ok    = duty_ok_q;
    assign locked     = locked_q;
    assign err        = err_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Scoreboard bench for clk_ratio_meter: a timestamp model predicts each
// measurement as the stimulus is driven; a monitor pops and compares.
module tb_clk_ratio_meter;

    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 4;
    localparam int TIMEOUT  = 255;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sig_in = 1'b1;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             duty_ok;
    logic             locked;
    logic             err;

    always #5 clk = ~clk;

    clk_ratio_meter #(
        .CNT_W    (CNT_W),
        .LOCK_CNT (LOCK_CNT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .duty_ok    (duty_ok),
        .locked     (locked),
        .err        (err)
    );

    typedef struct {
        int p;
        int h;
        bit d;
        bit l;
        bit e;
    } exp_t;

    exp_t q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model state (0 idle, 1 measure, 2 locked)
    bit m_prev = 1'b1;
    int m_state = 0;
    int m_t0 = 0;
    int m_h = 0;
    int m_ref = 0;
    bit m_ref_v = 1'b0;
    int m_match = 0;
    bit m_locked = 1'b0;
    int m_first_rise = 0;
    int exp_errs = 0;
    int exp_to_edge = -1;

    // Monitor observations
    int obs_errs = 0;
    int obs_meas = 0;
    int last_err_edge = -1;
    int lock_edge = -1;
    bit mon_prev_locked = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_prev    = 1'b1;
        m_state   = 0;
        m_ref_v   = 1'b0;
        m_match   = 0;
        m_locked  = 1'b0;
        lock_edge = -1;
    endtask

    task automatic model_step(input bit v, input int t);
        bit   r;
        exp_t ent;
        r = v && !m_prev;
        m_prev = v;
        if (r) begin
            if (m_state == 0) begin
                m_state = 1;
                m_first_rise = t;
            end else begin
                ent.p = t - m_t0;
                ent.h = m_h;
                ent.d = (2 * ent.h == ent.p);
                ent.e = 1'b0;
                if (m_ref_v && ent.p == m_ref && ent.d) begin
                    if (m_state == 1) begin
                        m_match++;
                        if (m_match == LOCK_CNT) begin
                            m_state = 2;
                            m_locked = 1'b1;
                        end
                    end
                end else begin
                    if (m_state == 2) begin
                        ent.e = 1'b1;
                        exp_errs++;
                        m_locked = 1'b0;
                        m_state = 1;
                    end
                    m_ref = ent.p;
                    m_ref_v = 1'b1;
                    m_match = 0;
                end
                ent.l = m_locked;
                q.push_back(ent);
            end
            m_t0 = t;
            m_h = 1;
        end else begin
            if (m_state != 0 && (t - m_t0) >= TIMEOUT) begin
                m_state = 0;
                m_locked = 1'b0;
                m_ref_v = 1'b0;
                m_match = 0;
                exp_errs++;
                exp_to_edge = t;
            end
            if (v) m_h++;
        end
    endtask

    task automatic drive(input bit v);
        @(negedge clk);
        sig_in = v;
        model_step(v, cyc);
    endtask

    task automatic pattern(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (hi) drive(1'b1);
            repeat (lo) drive(1'b0);
        end
    endtask

    // One reset edge, check every output cleared, then release with sig_in = s.
    task automatic do_reset(input bit s, input string tag);
        @(negedge clk);
        reset = 1'b1;
        sig_in = s;
        @(negedge clk);
        check_val({tag, "_period"}, period, 0);
        check_val({tag, "_high"}, high_time, 0);
        check_val({tag, "_mvalid"}, meas_valid, 0);
        check_val({tag, "_duty"}, duty_ok, 0);
        check_val({tag, "_locked"}, locked, 0);
        check_val({tag, "_err"}, err, 0);
        check_val({tag, "_q_empty"}, q.size(), 0);
        q.delete();
        reset = 1'b0;
        model_reset();
        model_step(s, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (err === 1'b1) begin
                obs_errs++;
                last_err_edge = cyc - 1;
            end
            if (meas_valid === 1'b1) begin
                obs_meas++;
                if (q.size() == 0) begin
                    check_val("unexpected_meas_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    check_val("period", period, e.p);
                    check_val("high_time", high_time, e.h);
                    check_val("duty_ok", duty_ok, e.d);
                    check_val("locked", locked, e.l);
                    check_val("err", err, e.e);
                    $display("meas: period=%0d high=%0d duty=%0b locked=%0b err=%0b", period, high_time, duty_ok, locked, err);
                end
            end
            if (locked === 1'b1 && !mon_prev_locked) lock_edge = cyc - 1;
            mon_prev_locked = (locked === 1'b1);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int err_base;
        int meas_base;

        repeat (2) @(negedge clk);

        // div2
        do_reset(1'b0, "rst0");
        pattern(1, 1, 8);
        repeat (2) drive(1'b0);
        check_val("div2_locked", locked, 1);
        check_val("div2_errs", obs_errs, 0);
        check_val("div2_q_empty", q.size(), 0);

        // div8: lock 40 cycles after the first rise
        do_reset(1'b0, "rst1");
        pattern(4, 4, 7);
        repeat (2) drive(1'b0);
        check_val("div8_locked", locked, 1);
        check_val("div8_lock_latency", lock_edge - m_first_rise, 40);
        check_val("div8_period", period, 8);

        // div4 lock, then switch to div8
        do_reset(1'b0, "rst2");
        pattern(2, 2, 7);
        check_val("div4_locked", locked, 1);
        err_base = obs_errs;
        pattern(4, 4, 6);
        repeat (2) drive(1'b0);
        check_val("relock_locked", locked, 1);
        check_val("relock_period", period, 8);
        check_val("relock_err_count", obs_errs - err_base, 1);
        check_val("err_total_a", obs_errs, exp_errs);

        // Loss of signal: exactly one err, TIMEOUT cycles after the last rise
        err_base = obs_errs;
        meas_base = obs_meas;
        repeat (TIMEOUT + 10) drive(1'b0);
        check_val("timeout_err_count", obs_errs - err_base, 1);
        check_val("timeout_err_delay", last_err_edge - m_t0, TIMEOUT);
        check_val("timeout_err_edge", last_err_edge, exp_to_edge);
        check_val("timeout_locked", locked, 0);
        check_val("timeout_no_meas", obs_meas - meas_base, 0);
        check_val("timeout_q_empty", q.size(), 0);

        // Odd period never locks
        do_reset(1'b0, "rst3");
        pattern(3, 2, 10);
        repeat (2) drive(1'b0);
        check_val("odd_locked", locked, 0);
        check_val("odd_duty", duty_ok, 0);
        check_val("odd_period", period, 5);

        // High at reset release, then div4; then reset mid-lock
        do_reset(1'b1, "rst4");
        meas_base = obs_meas;
        repeat (6) drive(1'b1);
        check_val("hi_release_no_meas", obs_meas - meas_base, 0);
        repeat (2) drive(1'b0);
        pattern(2, 2, 7);
        check_val("hi_release_locked", locked, 1);
        check_val("err_total_b", obs_errs, exp_errs);
        do_reset(1'b0, "rst_midlock");
        repeat (3) drive(1'b0);
        check_val("final_q_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
